// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, ALU operations and the
// bundles carried between pipeline stages.
package riscv_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] imm;
    alu_op_e     op;
    a_sel_e      a_sel;
    logic        b_imm;
    logic        wr;
    logic        ld;
    logic        st;
    logic        br;
    logic        jal;
    logic        jalr;
    logic [2:0]  f3;
  } id_ex_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wr;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] res;
    logic [31:0] sd;
  } ex_mem_t;

  typedef struct packed {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] data;
  } mem_wb_t;

  function automatic alu_op_e alu_dec(
    input logic [2:0] f3,
    input logic       alt,
    input logic       reg_op
  );
    case (f3)
      3'b000:  return (alt && reg_op) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/bram_bytewrite.sv
// Byte-lane RAM: asynchronous core port plus a registered external
// port; on a same-word collision the external lanes win.
module bram_bytewrite #(
  parameter int SIZE      = 128,
  parameter int NUM_COL   = 4,
  parameter int COL_WIDTH = 8,
  localparam int AW = $clog2(SIZE),
  localparam int W  = NUM_COL * COL_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [AW-1:0]      core_addr_i,
  input  logic [NUM_COL-1:0] core_we_i,
  input  logic [W-1:0]       core_din_i,
  output logic [W-1:0]       core_dout_o,
  input  logic [AW-1:0]      ext_addr_i,
  input  logic [NUM_COL-1:0] ext_we_i,
  input  logic [W-1:0]       ext_din_i,
  output logic [W-1:0]       ext_dout_o
);

  logic [NUM_COL-1:0][COL_WIDTH-1:0] mem [SIZE];
  logic [W-1:0] ext_dout_q;

  assign core_dout_o = mem[core_addr_i];
  assign ext_dout_o  = ext_dout_q;

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_COL; k++) begin
      if (core_we_i[k])
        mem[core_addr_i][k] <= core_din_i[k*COL_WIDTH +: COL_WIDTH];
      if (ext_we_i[k])
        mem[ext_addr_i][k] <= ext_din_i[k*COL_WIDTH +: COL_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ext_dout_q <= '0;
    else        ext_dout_q <= mem[ext_addr_i];
  end

endmodule

// File: rtl/pipelined_processor.sv
// 5-stage RV32I subset core with instruction/data RAMs that are
// also reachable through one shared external byte-addressed port.
module pipelined_processor
  import riscv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 128,
  parameter int NUM_COL   = 4,
  parameter int COL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       bram_din,
  input  logic [$clog2(SIZE)+2:0] shared_bram_addr,
  input  logic [NUM_COL-1:0]     bram_wr_en,
  output logic [WIDTH-1:0]       bram_dout
);

  localparam int AW = $clog2(SIZE);
  localparam int PW = AW + 2;

  logic [PW-1:0] pc_q, pc_d;
  if_id_t  if_id_q, if_id_d;
  id_ex_t  id_ex_q, id_ex_d, dec;
  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;
  logic [31:0] rf_q [32];

  logic [31:0] imem_rd, dmem_rd, dmem_wd, i_ext, d_ext;
  logic [3:0]  dmem_we, be;
  logic [NUM_COL-1:0] i_we, d_we;
  logic        sel_q, stall, taken, cond;
  logic [31:0] target, fa, fb, opa, opb, alu;
  logic [31:0] ld_sh, ld_v, rs1_v, rs2_v;
  logic [1:0]  ba;

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        ld_ok;

  assign i_we = shared_bram_addr[PW] ? '0 : bram_wr_en;
  assign d_we = shared_bram_addr[PW] ? bram_wr_en : '0;

  bram_bytewrite #(
    .SIZE(SIZE), .NUM_COL(NUM_COL), .COL_WIDTH(COL_WIDTH)
  ) u_imem (
    .clk         (clk),
    .rst_n       (reset),
    .core_addr_i (pc_q[PW-1:2]),
    .core_we_i   ('0),
    .core_din_i  ('0),
    .core_dout_o (imem_rd),
    .ext_addr_i  (shared_bram_addr[PW-1:2]),
    .ext_we_i    (i_we),
    .ext_din_i   (bram_din),
    .ext_dout_o  (i_ext)
  );

  bram_bytewrite #(
    .SIZE(SIZE), .NUM_COL(NUM_COL), .COL_WIDTH(COL_WIDTH)
  ) u_dmem (
    .clk         (clk),
    .rst_n       (reset),
    .core_addr_i (ex_mem_q.res[PW-1:2]),
    .core_we_i   (dmem_we),
    .core_din_i  (dmem_wd),
    .core_dout_o (dmem_rd),
    .ext_addr_i  (shared_bram_addr[PW-1:2]),
    .ext_we_i    (d_we),
    .ext_din_i   (bram_din),
    .ext_dout_o  (d_ext)
  );

  assign bram_dout = sel_q ? d_ext : i_ext;

  // ID: decode and register read (WB write bypasses the array)
  assign ins   = if_id_q.instr;
  assign opc   = ins[6:0];
  assign f3    = ins[14:12];
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};
  assign ld_ok = (f3 != 3'b011) && (f3[2:1] != 2'b11);

  assign rs1_v = (ins[19:15] == 5'd0) ? '0 :
                 (mem_wb_q.wr && mem_wb_q.rd == ins[19:15]) ?
                 mem_wb_q.data : rf_q[ins[19:15]];
  assign rs2_v = (ins[24:20] == 5'd0) ? '0 :
                 (mem_wb_q.wr && mem_wb_q.rd == ins[24:20]) ?
                 mem_wb_q.data : rf_q[ins[24:20]];

  always_comb begin
    dec       = '0;
    dec.pc    = if_id_q.pc;
    dec.rs1   = ins[19:15];
    dec.rs2   = ins[24:20];
    dec.rd    = ins[11:7];
    dec.f3    = f3;
    dec.rs1_v = rs1_v;
    dec.rs2_v = rs2_v;
    dec.op    = ALU_ADD;
    dec.a_sel = A_RS1;
    dec.imm   = imm_i;
    if (if_id_q.valid) begin
      unique case (1'b1)
        opc == OP_LUI: begin
          dec.wr = 1'b1; dec.a_sel = A_ZERO;
          dec.b_imm = 1'b1; dec.imm = imm_u;
        end
        opc == OP_AUIPC: begin
          dec.wr = 1'b1; dec.a_sel = A_PC;
          dec.b_imm = 1'b1; dec.imm = imm_u;
        end
        opc == OP_JAL: begin
          dec.wr = 1'b1; dec.jal = 1'b1; dec.imm = imm_j;
        end
        opc == OP_JALR: begin
          dec.wr = 1'b1; dec.jalr = 1'b1;
        end
        opc == OP_BR && f3[2:1] != 2'b01: begin
          dec.br = 1'b1; dec.imm = imm_b;
        end
        opc == OP_LD && ld_ok: begin
          dec.wr = 1'b1; dec.ld = 1'b1; dec.b_imm = 1'b1;
        end
        opc == OP_ST && f3 < 3'd3: begin
          dec.st = 1'b1; dec.b_imm = 1'b1; dec.imm = imm_s;
        end
        opc == OP_IMM: begin
          dec.wr = 1'b1; dec.b_imm = 1'b1;
          dec.op = alu_dec(f3, ins[30], 1'b0);
        end
        opc == OP_OP: begin
          dec.wr = 1'b1;
          dec.op = alu_dec(f3, ins[30], 1'b1);
        end
        default: ;
      endcase
    end
    if (dec.rd == 5'd0) dec.wr = 1'b0;
  end

  assign stall = id_ex_q.ld && id_ex_q.wr &&
                 (id_ex_q.rd == ins[19:15] ||
                  id_ex_q.rd == ins[24:20]);

  // EX: operand forwarding, ALU and branch resolution
  always_comb begin
    fa = id_ex_q.rs1_v;
    if (ex_mem_q.wr && ex_mem_q.rd == id_ex_q.rs1)
      fa = ex_mem_q.res;
    else if (mem_wb_q.wr && mem_wb_q.rd == id_ex_q.rs1)
      fa = mem_wb_q.data;
    fb = id_ex_q.rs2_v;
    if (ex_mem_q.wr && ex_mem_q.rd == id_ex_q.rs2)
      fb = ex_mem_q.res;
    else if (mem_wb_q.wr && mem_wb_q.rd == id_ex_q.rs2)
      fb = mem_wb_q.data;
  end

  always_comb begin
    case (id_ex_q.a_sel)
      A_PC:    opa = id_ex_q.pc;
      A_ZERO:  opa = '0;
      default: opa = fa;
    endcase
    opb = id_ex_q.b_imm ? id_ex_q.imm : fb;
    case (id_ex_q.op)
      ALU_SUB:  alu = opa - opb;
      ALU_SLL:  alu = opa << opb[4:0];
      ALU_SLT:  alu = {31'b0, $signed(opa) < $signed(opb)};
      ALU_SLTU: alu = {31'b0, opa < opb};
      ALU_XOR:  alu = opa ^ opb;
      ALU_SRL:  alu = opa >> opb[4:0];
      ALU_SRA:  alu = $unsigned($signed(opa) >>> opb[4:0]);
      ALU_OR:   alu = opa | opb;
      ALU_AND:  alu = opa & opb;
      default:  alu = opa + opb;
    endcase
  end

  always_comb begin
    case (id_ex_q.f3)
      F3_BEQ:  cond = fa == fb;
      F3_BNE:  cond = fa != fb;
      F3_BLT:  cond = $signed(fa) < $signed(fb);
      F3_BGE:  cond = $signed(fa) >= $signed(fb);
      F3_BLTU: cond = fa < fb;
      default: cond = fa >= fb;
    endcase
    taken  = (id_ex_q.br && cond) || id_ex_q.jal || id_ex_q.jalr;
    target = id_ex_q.jalr ? ((fa + id_ex_q.imm) & ~32'd1)
                          : (id_ex_q.pc + id_ex_q.imm);
    ex_mem_d.rd  = id_ex_q.rd;
    ex_mem_d.wr  = id_ex_q.wr;
    ex_mem_d.ld  = id_ex_q.ld;
    ex_mem_d.st  = id_ex_q.st;
    ex_mem_d.f3  = id_ex_q.f3;
    ex_mem_d.res = (id_ex_q.jal || id_ex_q.jalr) ?
                   id_ex_q.pc + 32'd4 : alu;
    ex_mem_d.sd  = fb;
  end

  // MEM: lanes follow addr[1:0] even when misaligned
  assign ba = ex_mem_q.res[1:0];

  always_comb begin
    case (ex_mem_q.f3[1:0])
      2'b00:   be = 4'b0001;
      2'b01:   be = 4'b0011;
      default: be = 4'b1111;
    endcase
    dmem_we = ex_mem_q.st ? be << ba : 4'b0000;
    dmem_wd = ex_mem_q.sd << {ba, 3'b000};
    ld_sh   = dmem_rd >> {ba, 3'b000};
    case (ex_mem_q.f3)
      3'b000:  ld_v = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_v = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b100:  ld_v = {24'b0, ld_sh[7:0]};
      3'b101:  ld_v = {16'b0, ld_sh[15:0]};
      default: ld_v = ld_sh;
    endcase
    mem_wb_d.wr   = ex_mem_q.wr;
    mem_wb_d.rd   = ex_mem_q.rd;
    mem_wb_d.data = ex_mem_q.ld ? ld_v : ex_mem_q.res;
  end

  // IF and hazard steering; a taken branch outranks a stall
  always_comb begin
    pc_d           = pc_q + PW'(4);
    if_id_d.valid  = 1'b1;
    if_id_d.pc     = 32'(pc_q);
    if_id_d.instr  = imem_rd;
    id_ex_d        = dec;
    if (taken) begin
      pc_d    = target[PW-1:0];
      if_id_d = '0;
      id_ex_d = '0;
    end else if (stall) begin
      pc_d    = pc_q;
      if_id_d = if_id_q;
      id_ex_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
      sel_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
      sel_q    <= shared_bram_addr[PW];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wb_q.wr) rf_q[mem_wb_q.rd] <= mem_wb_q.data;
  end

  logic unused_ok;
  assign unused_ok = ^{target[31:PW], ex_mem_q.res[31:PW],
                       shared_bram_addr[1:0]};

endmodule

// File: tb/tb_pipelined_processor.sv
// Bench: external-port vectors, random port traffic against a word
// model, and short programs checking forwarding, stalls and flushes.
module tb_pipelined_processor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] bram_din;
  logic [9:0]  shared_bram_addr;
  logic [3:0]  bram_wr_en;
  logic [31:0] bram_dout;

  int checks = 0;
  int failures = 0;

  logic [31:0] model [256];
  logic [31:0] prog [8];

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  we;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [12];

  logic [9:0]  ra;
  logic [31:0] rd_, rexp;
  logic [3:0]  rwe;

  pipelined_processor dut (
    .clk              (clk),
    .reset            (reset),
    .bram_din         (bram_din),
    .shared_bram_addr (shared_bram_addr),
    .bram_wr_en       (bram_wr_en),
    .bram_dout        (bram_dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic ext(input logic [9:0] a, input logic [31:0] d,
                     input logic [3:0] we);
    shared_bram_addr = a;
    bram_din = d;
    bram_wr_en = we;
    tick();
    for (int k = 0; k < 4; k++)
      if (we[k]) model[a[9:2]][k*8 +: 8] = d[k*8 +: 8];
    bram_wr_en = 4'h0;
  endtask

  task automatic rd_chk(input string nm, input logic [9:0] a,
                        input logic [31:0] exp);
    ext(a, 32'h0, 4'h0);
    chk(nm, bram_dout, exp);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 8; i++) ext(10'(i * 4), prog[i], 4'hF);
  endtask

  task automatic set_prog(input logic [31:0] p0, input logic [31:0] p1,
                          input logic [31:0] p2, input logic [31:0] p3,
                          input logic [31:0] p4, input logic [31:0] p5);
    prog[0] = p0; prog[1] = p1; prog[2] = p2;
    prog[3] = p3; prog[4] = p4; prog[5] = p5;
    prog[6] = 32'h00000013;
    prog[7] = 32'h00000013;
  endtask

  initial begin
    reset = 1'b0;
    bram_din = '0;
    shared_bram_addr = '0;
    bram_wr_en = '0;
    tick();
    chk("reset_dout", bram_dout, 32'h0);

    for (int i = 0; i < 1024; i += 4) ext(10'(i), 32'(i), 4'hF);
    chk("dout_held_in_reset", bram_dout, 32'h0);
    reset = 1'b1;
    rd_chk("fill_204", 10'h204, 32'h204);
    rd_chk("fill_000", 10'h000, 32'h0);

    tbl[0]  = '{10'h200, 32'h11223344, 4'hF, 32'h00000200};
    tbl[1]  = '{10'h200, 32'hAABBCCDD, 4'h1, 32'h11223344};
    tbl[2]  = '{10'h200, 32'h00000000, 4'h0, 32'h112233DD};
    tbl[3]  = '{10'h202, 32'h00000000, 4'h0, 32'h112233DD};
    tbl[4]  = '{10'h204, 32'hA5A50000, 4'hC, 32'h00000204};
    tbl[5]  = '{10'h204, 32'h00000000, 4'h0, 32'hA5A50204};
    tbl[6]  = '{10'h004, 32'h00007700, 4'h2, 32'h00000004};
    tbl[7]  = '{10'h004, 32'h00000000, 4'h0, 32'h00007704};
    tbl[8]  = '{10'h3FC, 32'h00000000, 4'h0, 32'h000003FC};
    tbl[9]  = '{10'h1FC, 32'h00000000, 4'h0, 32'h000001FC};
    tbl[10] = '{10'h204, 32'h12345678, 4'h0, 32'hA5A50204};
    tbl[11] = '{10'h204, 32'h00000000, 4'h0, 32'hA5A50204};
    for (int i = 0; i < 12; i++) begin
      ext(tbl[i].a, tbl[i].d, tbl[i].we);
      chk($sformatf("vec%0d", i), bram_dout, tbl[i].exp);
    end

    // low two bits cleared so instruction words always decode as NOP
    for (int n = 0; n < 200; n++) begin
      ra   = 10'($urandom_range(0, 1023));
      rd_  = $urandom & 32'hFFFF_FFFC;
      rwe  = 4'($urandom);
      rexp = model[ra[9:2]];
      ext(ra, rd_, rwe);
      chk($sformatf("rand%0d@%03h", n, ra), bram_dout, rexp);
    end

    reset = 1'b0;
    tick();
    set_prog(32'h00500093, 32'h00308113, 32'h00202023,
             32'h00000013, 32'h00000013, 32'h00000013);
    load_prog();
    ext(10'h200, 32'hFFFFFFFF, 4'hF);
    reset = 1'b1;
    repeat (10) tick();
    rd_chk("fwd_sw", 10'h200, 32'd8);

    reset = 1'b0;
    tick();
    set_prog(32'h00002183, 32'h00318233, 32'h00402223,
             32'h00000013, 32'h00000013, 32'h00000013);
    load_prog();
    ext(10'h200, 32'd7, 4'hF);
    ext(10'h204, 32'h0, 4'hF);
    reset = 1'b1;
    repeat (12) tick();
    rd_chk("load_use", 10'h204, 32'd14);

    reset = 1'b0;
    tick();
    set_prog(32'h00000293, 32'h00000463, 32'h00100293,
             32'h00502423, 32'h00000013, 32'h00000013);
    load_prog();
    ext(10'h208, 32'h12345678, 4'hF);
    reset = 1'b1;
    repeat (12) tick();
    rd_chk("branch_flush", 10'h208, 32'h0);

    reset = 1'b0;
    tick();
    set_prog(32'h80000437, 32'h40445493, 32'h00902A23,
             32'h01700503, 32'h00A02C23, 32'h00000013);
    load_prog();
    ext(10'h214, 32'h0, 4'hF);
    ext(10'h218, 32'h0, 4'hF);
    reset = 1'b1;
    repeat (16) tick();
    rd_chk("lui_srai_sw", 10'h214, 32'hF8000000);
    rd_chk("lb_sign", 10'h218, 32'hFFFFFFF8);

    reset = 1'b0;
    tick();
    set_prog(32'h00900393, 32'h00702623, 32'h00000013,
             32'h00000013, 32'h00000013, 32'h00000013);
    load_prog();
    ext(10'h20C, 32'h000000AA, 4'hF);
    ext(10'h210, 32'h0, 4'hF);
    shared_bram_addr = 10'h20C;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("async_reset_dout", bram_dout, 32'h0);
    tick();
    set_prog(32'h00300393, 32'h00702823, 32'h00000013,
             32'h00000013, 32'h00000013, 32'h00000013);
    load_prog();
    reset = 1'b1;
    repeat (12) tick();
    rd_chk("no_spurious_store", 10'h20C, 32'h000000AA);
    rd_chk("restart_at_0", 10'h210, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
